rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths, default starvation bound and arbiter state type for the regfile writeback arbiter.
// Optional feature macro used by this slice: RF_WB_SCOREBOARD_EN.
package rf_wb_pkg;
  localparam int REG_ADDR_W         = 5;
  localparam int DATA_W             = 32;
  localparam int NUM_REGS           = 2 ** REG_ADDR_W;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  function automatic logic addr_nonzero(input logic [REG_ADDR_W-1:0] addr);
    return addr != {REG_ADDR_W{1'b0}};
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-op destinations; x0 is never tracked and set beats clear.
// Only instantiated when RF_WB_SCOREBOARD_EN is defined.
module rf_scoreboard
  import rf_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_q1_addr,
  input  logic [REG_ADDR_W-1:0] i_q2_addr,
  output logic                  o_q1_busy,
  output logic                  o_q2_busy
);
  logic [NUM_REGS-1:1] r_pending;
  logic [NUM_REGS-1:1] w_pending_nxt;
  logic [NUM_REGS-1:0] w_pending_full;

  // Next pending vector: a same-cycle set of a register overrides its clear
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i_set_en && (i_set_addr == REG_ADDR_W'(i))) begin
        w_pending_nxt[i] = 1'b1;
      end else if (i_clr_en && (i_clr_addr == REG_ADDR_W'(i))) begin
        w_pending_nxt[i] = 1'b0;
      end else begin
        w_pending_nxt[i] = r_pending[i];
      end
    end
  end

  // Pending storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= {(NUM_REGS-1){1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign w_pending_full = {r_pending, 1'b0};
  assign o_q1_busy      = w_pending_full[i_q1_addr];
  assign o_q2_busy      = w_pending_full[i_q2_addr];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single regfile write port between the pipeline WB stage and a one-entry long-op buffer,
// forcing the buffer through after STARVE_MAX losses. Scoreboard enabled by RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  p_valid,
  input  logic [REG_ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0]     p_wdata,
  output logic                  p_stall,
  input  logic                  m_valid,
  input  logic [REG_ADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0]     m_wdata,
  output logic                  m_ready,
  input  logic                  m_issue,
  input  logic [REG_ADDR_W-1:0] m_issue_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
);
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e            r_state;
  logic                  r_buf_v;
  logic [REG_ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0]     r_buf_data;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  w_p_take;
  logic                  w_commit;

  assign w_p_take = p_valid && addr_nonzero(p_waddr);
  assign m_ready  = !r_buf_v;

  // Write-port mux and stall; address/data forced to zero whenever nothing is written
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = {REG_ADDR_W{1'b0}};
    rf_wdata = {DATA_W{1'b0}};
    p_stall  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_FORCE: begin
        p_stall = p_valid;
        if (r_buf_v) begin
          rf_we    = 1'b1;
          rf_waddr = r_buf_addr;
          rf_wdata = r_buf_data;
          w_commit = 1'b1;
        end else begin
          rf_we    = 1'b0;
        end
      end
      ST_NORMAL: begin
        if (w_p_take) begin
          rf_we    = 1'b1;
          rf_waddr = p_waddr;
          rf_wdata = p_wdata;
        end else if (r_buf_v) begin
          rf_we    = 1'b1;
          rf_waddr = r_buf_addr;
          rf_wdata = r_buf_data;
          w_commit = 1'b1;
        end else begin
          rf_we    = 1'b0;
        end
      end
      default: begin
        rf_we    = 1'b0;
      end
    endcase
  end

  // Arbitration FSM, long-op buffer and starvation counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_NORMAL;
      r_buf_v      <= 1'b0;
      r_buf_addr   <= {REG_ADDR_W{1'b0}};
      r_buf_data   <= {DATA_W{1'b0}};
      r_starve_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_commit) begin
        r_buf_v <= 1'b0;
      end else if (m_valid && !r_buf_v && addr_nonzero(m_waddr)) begin
        r_buf_v    <= 1'b1;
        r_buf_addr <= m_waddr;
        r_buf_data <= m_wdata;
      end
      case (r_state)
        ST_NORMAL: begin
          if (r_buf_v && w_p_take) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            if (r_starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
              r_state <= ST_FORCE;
            end
          end else if (w_commit) begin
            r_starve_cnt <= {CNT_W{1'b0}};
          end
        end
        ST_FORCE: begin
          r_state      <= ST_NORMAL;
          r_starve_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_state      <= ST_NORMAL;
          r_starve_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic w_rs1_busy;
  logic w_rs2_busy;

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .resetn     (resetn),
    .i_set_en   (m_issue),
    .i_set_addr (m_issue_addr),
    .i_clr_en   (w_commit),
    .i_clr_addr (r_buf_addr),
    .i_q1_addr  (rs1_addr),
    .i_q2_addr  (rs2_addr),
    .o_q1_busy  (w_rs1_busy),
    .o_q2_busy  (w_rs2_busy)
  );

  assign rs_busy = w_rs1_busy | w_rs2_busy;
`else
  logic w_unused_sb;

  assign w_unused_sb = ^{m_issue, m_issue_addr, rs1_addr, rs2_addr};
  assign rs_busy     = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized plus directed bench for rf_wb_arbiter against a transaction-level model of the port sharing.
// Busy expectations follow RF_WB_SCOREBOARD_EN.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int SM = STARVE_MAX_DEFAULT;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        p_valid, m_valid, m_issue;
  logic [4:0]  p_waddr, m_waddr, m_issue_addr, rs1_addr, rs2_addr;
  logic [31:0] p_wdata, m_wdata;
  logic        p_stall, m_ready, rs_busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the buffered long-op write, how often it has lost the port, and pending registers
  bit          mb_v;
  bit [4:0]    mb_a;
  bit [31:0]   mb_d;
  int          losses;
  bit [31:0]   pend;
  bit          e_we, e_stall, e_ready, e_busy, e_commit, e_take;
  bit [4:0]    e_wa;
  bit [31:0]   e_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_stall(p_stall),
    .m_valid(m_valid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_ready(m_ready),
    .m_issue(m_issue), .m_issue_addr(m_issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_busy(rs_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb_v = 1'b0; mb_a = '0; mb_d = '0; losses = 0; pend = '0;
  endtask

  // Buffer goes out when the port is free, or unconditionally once it has lost SM times
  task automatic model_eval();
    e_take = p_valid && (p_waddr != 5'd0);
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_stall = 1'b0; e_commit = 1'b0;
    if (mb_v && losses >= SM) begin
      e_we = 1'b1; e_wa = mb_a; e_wd = mb_d; e_stall = p_valid; e_commit = 1'b1;
    end else if (e_take) begin
      e_we = 1'b1; e_wa = p_waddr; e_wd = p_wdata;
    end else if (mb_v) begin
      e_we = 1'b1; e_wa = mb_a; e_wd = mb_d; e_commit = 1'b1;
    end
    e_ready = !mb_v;
    e_busy  = SB && (pend[rs1_addr] || pend[rs2_addr]);
  endtask

  task automatic model_update();
    if (e_commit) begin
      mb_v = 1'b0; losses = 0; pend[mb_a] = 1'b0;
    end else if (mb_v && e_take) begin
      losses++;
    end
    if (m_valid && e_ready && m_waddr != 5'd0) begin
      mb_v = 1'b1; mb_a = m_waddr; mb_d = m_wdata;
    end
    if (m_issue && m_issue_addr != 5'd0) pend[m_issue_addr] = 1'b1;
    pend[0] = 1'b0;
  endtask

  task automatic drive(input bit pv, input bit [4:0] pa, input bit [31:0] pd,
                       input bit mv, input bit [4:0] ma, input bit [31:0] md,
                       input bit mi, input bit [4:0] mia, input bit [4:0] q1, input bit [4:0] q2);
    @(negedge clk);
    p_valid = pv; p_waddr = pa; p_wdata = pd;
    m_valid = mv; m_waddr = ma; m_wdata = md;
    m_issue = mi; m_issue_addr = mia; rs1_addr = q1; rs2_addr = q2;
    #1;
    model_eval();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_we"},    rf_we,    e_we);
    chk({tag, "_waddr"}, rf_waddr, e_wa);
    chk({tag, "_wdata"}, rf_wdata, e_wd);
    chk({tag, "_stall"}, p_stall,  e_stall);
    chk({tag, "_ready"}, m_ready,  e_ready);
    chk({tag, "_busy"},  rs_busy,  e_busy);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input string tag, input bit pv, input bit [4:0] pa, input bit [31:0] pd,
                     input bit mv, input bit [4:0] ma, input bit [31:0] md,
                     input bit mi, input bit [4:0] mia, input bit [4:0] q1, input bit [4:0] q2);
    drive(pv, pa, pd, mv, ma, md, mi, mia, q1, q2);
    check_all(tag);
    finish_cycle();
  endtask

  initial begin
    bit          hold_p;
    bit          pv, mv, mi;
    bit [4:0]    pa, ma, mia;
    bit [31:0]   pd;

    resetn = 1'b0;
    p_valid = 1'b1; p_waddr = 5'd6; p_wdata = 32'h66; m_valid = 1'b0; m_waddr = 5'd0;
    m_wdata = 32'd0; m_issue = 1'b0; m_issue_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    model_reset();
    #12;
    chk("rst_ready", m_ready, 1'b1);
    chk("rst_stall", p_stall, 1'b0);
    chk("rst_busy",  rs_busy, 1'b0);
    chk("rst_we",    rf_we,   1'b1);
    chk("rst_waddr", rf_waddr, 32'd6);
    @(negedge clk);
    resetn = 1'b1;

    // Idle port: long-op write lands the next cycle
    cyc("idle0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("idle_we", rf_we, 1'b1);
    chk("idle_waddr", rf_waddr, 32'd5);
    chk("idle_wdata", rf_wdata, 32'h1234);
    chk("idle_ready0", m_ready, 1'b0);
    check_all("idle1");
    finish_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("idle_ready1", m_ready, 1'b1);
    check_all("idle2");
    finish_cycle();

    // Contention: buffered r7 loses SM times, is forced, then r3 goes through
    cyc("cont_ld", 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < SM; i++) begin
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("cont_p_addr", rf_waddr, 32'd3);
      check_all("cont_lose");
      finish_cycle();
    end
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("cont_force_addr", rf_waddr, 32'd7);
    chk("cont_force_stall", p_stall, 1'b1);
    check_all("cont_force");
    finish_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("cont_after_addr", rf_waddr, 32'd3);
    chk("cont_after_stall", p_stall, 1'b0);
    check_all("cont_after");
    finish_cycle();

    // x0 handling on both sides
    cyc("x0_ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_p_commit", rf_waddr, 32'd12);
    check_all("x0_p");
    finish_cycle();
    cyc("x0_m", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_m_ready", m_ready, 1'b1);
    chk("x0_m_we", rf_we, 1'b0);
    finish_cycle();

    // Scoreboard: same-cycle commit and reissue of r9 keeps it busy
    cyc("sb_iss", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    cyc("sb_ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd0);
    cyc("sb_cmt_iss", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd0, 5'd9);
    chk("sb_set_wins", rs_busy, SB);
    check_all("sb_ld2");
    finish_cycle();
    cyc("sb_cmt", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("sb_cleared", rs_busy, 1'b0);
    finish_cycle();

    // Reset while in FORCE with r9 buffered and pending
    cyc("rf_iss", 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0);
    for (int i = 0; i < SM; i++)
      cyc("rf_lose", 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("rf_in_force", p_stall, 1'b1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rf_ready", m_ready, 1'b1);
    chk("rf_stall", p_stall, 1'b0);
    chk("rf_busy", rs_busy, 1'b0);
    chk("rf_we_p", rf_waddr, 32'd3);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("rf_post", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);

    // Random traffic; pipeline holds p_* while stalled, issues only to non-pending registers
    hold_p = 1'b0; pv = 1'b0; pa = 5'd0; pd = 32'd0;
    for (int c = 0; c < 800; c++) begin
      if (!hold_p) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = 5'($urandom_range(0, 31));
        pd = $urandom();
      end
      mv  = $urandom_range(0, 1) == 1;
      ma  = 5'($urandom_range(0, 31));
      mia = 5'($urandom_range(1, 31));
      mi  = ($urandom_range(0, 3) == 0) && !pend[mia];
      drive(pv, pa, pd, mv, ma, $urandom(), mi, mia,
            5'($urandom_range(0, 31)), (c % 2 == 0) ? mb_a : 5'($urandom_range(0, 31)));
      check_all("rnd");
      hold_p = e_stall;
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
